// File: rtl/dca_matrix_rdata_aligner.sv
// Realigns a stream of memory read beats by a per-transaction bit offset and tags each output row with a column mask.
// Optional macro DCA_MATRIX_RDATA_ALIGNER_SUBBYTE_EN enables bit-granular offsets; otherwise offsets are byte-granular.
module dca_matrix_rdata_aligner #(
   parameter int BW_ROW = 128,
   parameter int NUM_COL = 4,
   parameter int BW_ID = 4,
   localparam int BW_OFFSET = $clog2(BW_ROW)
) (
   input  logic                 clk,
   input  logic                 rstnn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BW_ROW-1:0]    in_data,
   input  logic                 in_last,
   input  logic [BW_OFFSET-1:0] in_offset,
   input  logic [2:0]           in_elem_log2,
   input  logic [NUM_COL-1:0]   in_col_mask,
   input  logic [BW_ID-1:0]     in_id,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BW_ROW-1:0]    out_data,
   output logic [BW_ROW-1:0]    out_mask,
   output logic                 out_last,
   output logic [BW_ID-1:0]     out_id,
   output logic [7:0]           out_beat_idx
);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                state_q, state_d;
   logic [BW_OFFSET-1:0]  offset_q, offset_d;
   logic [2:0]            elem_log2_q, elem_log2_d;
   logic [NUM_COL-1:0]    col_mask_q, col_mask_d;
   logic [BW_ID-1:0]      id_q, id_d;
   logic [BW_ROW-1:0]     hold_q, hold_d;
   logic                  out_valid_q, out_valid_d;
   logic [BW_ROW-1:0]     out_data_q, out_data_d;
   logic [BW_ROW-1:0]     out_mask_q, out_mask_d;
   logic                  out_last_q, out_last_d;
   logic [BW_ID-1:0]      out_id_q, out_id_d;
   logic [7:0]            out_beat_idx_q, out_beat_idx_d;
   logic [7:0]            idx_cnt_q, idx_cnt_d;

   logic                  in_hs;
   logic [BW_OFFSET-1:0]  eff_offset;
   logic                  produce;
   logic [BW_ROW-1:0]     prod_data;
   logic                  prod_last;
   logic [7:0]            idx_base;
   logic [2:0]            mask_elem;
   logic [NUM_COL-1:0]    mask_cols;
   logic [2*BW_ROW-1:0]   funnel;

`ifdef DCA_MATRIX_RDATA_ALIGNER_SUBBYTE_EN
   assign eff_offset = in_offset;
`else
   assign eff_offset = in_offset & ~BW_OFFSET'(7);
`endif

   assign in_ready = !out_valid_q || out_ready;
   assign in_hs    = in_valid && in_ready;

   // Bit j is owned by element column j >> elem_log2; oversized elements select nothing.
   function automatic logic [BW_ROW-1:0] build_mask(input logic [2:0] el, input logic [NUM_COL-1:0] cm);
      logic [BW_ROW-1:0]  m;
      logic [NUM_COL-1:0] sel;
      int                 col;
      m = '0;
      if (el <= 3'd5) begin
         for (int j = 0; j < BW_ROW; j++) begin
            col = j >> el;
            if (col < NUM_COL) begin
               sel  = cm >> col;
               m[j] = sel[0];
            end
         end
      end
      return m;
   endfunction

   always_comb begin
      state_d        = state_q;
      offset_d       = offset_q;
      elem_log2_d    = elem_log2_q;
      col_mask_d     = col_mask_q;
      id_d           = id_q;
      hold_d         = hold_q;
      out_valid_d    = out_valid_q;
      out_data_d     = out_data_q;
      out_mask_d     = out_mask_q;
      out_last_d     = out_last_q;
      out_id_d       = out_id_q;
      out_beat_idx_d = out_beat_idx_q;
      idx_cnt_d      = idx_cnt_q;
      produce        = 1'b0;
      prod_data      = '0;
      prod_last      = 1'b0;
      funnel         = '0;
      idx_base       = (state_q == IDLE) ? 8'd0 : idx_cnt_q;
      mask_elem      = (state_q == IDLE) ? in_elem_log2 : elem_log2_q;
      mask_cols      = (state_q == IDLE) ? in_col_mask : col_mask_q;

      case (state_q)
         IDLE: begin
            if (in_hs) begin
               offset_d    = eff_offset;
               elem_log2_d = in_elem_log2;
               col_mask_d  = in_col_mask;
               id_d        = in_id;
               idx_cnt_d   = 8'd0;
               if (eff_offset == '0) begin
                  produce   = 1'b1;
                  prod_data = in_data;
                  prod_last = in_last;
                  state_d   = in_last ? IDLE : STREAM;
               end else if (!in_last) begin
                  hold_d  = in_data;
                  state_d = STREAM;
               end else begin
                  produce   = 1'b1;
                  prod_data = in_data >> eff_offset;
                  prod_last = 1'b1;
               end
            end
         end
         STREAM: begin
            if (in_hs) begin
               produce   = 1'b1;
               prod_last = in_last;
               if (offset_q == '0) begin
                  prod_data = in_data;
               end else begin
                  funnel    = {in_data, hold_q} >> offset_q;
                  prod_data = funnel[BW_ROW-1:0];
                  hold_d    = in_data;
               end
               if (in_last) begin
                  state_d = IDLE;
               end
            end
         end
      endcase

      // A newly produced beat replaces whatever was being consumed this cycle.
      if (produce) begin
         out_valid_d    = 1'b1;
         out_data_d     = prod_data;
         out_last_d     = prod_last;
         out_mask_d     = build_mask(mask_elem, mask_cols);
         out_id_d       = (state_q == IDLE) ? in_id : id_q;
         out_beat_idx_d = idx_base;
         idx_cnt_d      = prod_last ? 8'd0 : idx_base + 8'd1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state_q        <= IDLE;
         offset_q       <= '0;
         elem_log2_q    <= '0;
         col_mask_q     <= '0;
         id_q           <= '0;
         hold_q         <= '0;
         out_valid_q    <= 1'b0;
         out_data_q     <= '0;
         out_mask_q     <= '0;
         out_last_q     <= 1'b0;
         out_id_q       <= '0;
         out_beat_idx_q <= '0;
         idx_cnt_q      <= '0;
      end else begin
         state_q        <= state_d;
         offset_q       <= offset_d;
         elem_log2_q    <= elem_log2_d;
         col_mask_q     <= col_mask_d;
         id_q           <= id_d;
         hold_q         <= hold_d;
         out_valid_q    <= out_valid_d;
         out_data_q     <= out_data_d;
         out_mask_q     <= out_mask_d;
         out_last_q     <= out_last_d;
         out_id_q       <= out_id_d;
         out_beat_idx_q <= out_beat_idx_d;
         idx_cnt_q      <= idx_cnt_d;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign out_mask     = out_mask_q;
   assign out_last     = out_last_q;
   assign out_id       = out_id_q;
   assign out_beat_idx = out_beat_idx_q;

endmodule

// File: doc/dca_matrix_rdata_aligner.md
DCA_MATRIX_RDATA_ALIGNER -- requirements
Module: dca_matrix_rdata_aligner

Interface
REQ-001 SHALL have parameter BW_ROW, default 128: row-buffer width in bits, power of two, 32..1024.
REQ-002 SHALL have parameter NUM_COL, default 4: matrix columns, 1..BW_ROW.
REQ-003 SHALL have parameter BW_ID, default 4: transaction-id width.
REQ-004 SHALL derive localparam BW_OFFSET = log2(BW_ROW).
REQ-005 SHALL have ports, in order:
- clk  input  1  sole clock.
- rstnn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted.
- in_data  input  BW_ROW  memory read beat.
- in_last  input  1  final input beat of transaction.
- in_offset  input  BW_OFFSET  bit offset of first element; sampled on first beat only.
- in_elem_log2  input  3  log2 element bits (0..5 = 1..32 bits); first beat only.
- in_col_mask  input  NUM_COL  per-column enable; first beat only.
- in_id  input  BW_ID  transaction id; first beat only.
- out_valid  output  1  aligned beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  BW_ROW  aligned row.
- out_mask  output  BW_ROW  bit-level valid mask.
- out_last  output  1  final aligned beat.
- out_id  output  BW_ID  id of current transaction.
- out_beat_idx  output  8  aligned-beat index within transaction.

Function
REQ-006 SHALL complete an input handshake when in_valid && in_ready; an output handshake when out_valid && out_ready.
REQ-007 SHALL drive in_ready = !out_valid || out_ready, combinationally, in every state.
REQ-008 SHALL implement states IDLE (awaiting first beat) and STREAM (mid-transaction).
REQ-009 In IDLE on input handshake SHALL latch offset, elem_log2, col_mask, id into transaction registers.
REQ-010 In IDLE with effective offset 0: SHALL register out_data=in_data, out_last=in_last; next state STREAM unless in_last.
REQ-011 In IDLE with effective offset nonzero and !in_last: SHALL load hold register with in_data, produce no output, go STREAM.
REQ-012 In IDLE with effective offset nonzero and in_last: SHALL output low BW_ROW bits of ({BW_ROW zeros, in_data} >> offset), out_last=1, stay IDLE.
REQ-013 In STREAM with offset 0: SHALL pass in_data to output; with offset nonzero: SHALL output low BW_ROW bits of ({in_data, hold} >> offset) and load hold with in_data.
REQ-014 In STREAM, on handshake with in_last: SHALL set out_last=1 and return to IDLE.
REQ-015 Latency: output registered; out_valid rises the cycle after the producing input handshake; throughput one beat/cycle with out_ready held high.
REQ-016 out_valid SHALL clear after output handshake unless a new beat is produced in the same cycle; out_* SHALL hold stable while out_valid && !out_ready.
REQ-017 out_mask bit j SHALL equal col_mask[j >> elem_log2] when (j >> elem_log2) < NUM_COL, else 0; elem_log2 6 or 7 SHALL give all-zero mask.
REQ-018 out_mask and out_id SHALL be constant across all beats of a transaction.
REQ-019 out_beat_idx SHALL be 0 on first output beat, +1 per output beat, wrap 255->0, restart at 0 after out_last.
REQ-020 An input beat accepted in the same cycle as the out_last handshake SHALL be treated as a first beat.

Reset
REQ-021 On rstnn low SHALL asynchronously force: state IDLE; out_valid, out_last 0; out_data, out_mask, hold 0; out_id, out_beat_idx 0; transaction registers 0.
REQ-022 Reset mid-transaction SHALL discard hold data; first beat after release is a new transaction.
REQ-023 in_ready SHALL be 1 while in reset (out_valid=0).

Configuration
REQ-024 Macro DCA_MATRIX_RDATA_ALIGNER_SUBBYTE_EN: when defined, effective offset = full in_offset; when undefined, in_offset[2:0] SHALL be forced to 0 (byte-granular alignment only), including the offset-0 decision of REQ-010/011.

Verification
REQ-025 BW_ROW=128, offset 0, 3 beats A,B,C, out_ready=1 -> outputs A,B,C on consecutive cycles, idx 0,1,2, out_last on C.
REQ-026 offset 32, beats X0,X1,X2 -> 2 outputs: {X1[31:0],X0[127:32]}, {X2[31:0],X1[127:32]}, last on second.
REQ-027 offset 64, single beat with in_last, data 0x...AAAA_BBBB -> one output = in_data>>64, out_last=1, state IDLE.
REQ-028 col_mask 4'b0101, elem_log2 5 -> out_mask bits [31:0] and [95:64] set, others 0; elem_log2 6 -> mask 0.
REQ-029 out_ready low 5 cycles mid-stream -> in_ready low, out_* stable, no beat lost or duplicated.
REQ-030 offset 3 with macro undefined -> behaves as offset 0; with macro defined -> output = funnel shift by 3; rstnn pulsed mid-stream -> out_valid 0 immediately, next beat treated as first.
